spram_fifo_banked: RTL and testbench
====================================

Name: spram_fifo_banked

Overview:
- Synchronous FIFO built from NUM_BANKS interleaved single-port RAM banks. Each bank does one read or one write per cycle, never both.
- Entry k is stored in bank k mod NUM_BANKS, so steady read and write streams land on different banks.
- Valid/ready handshakes on both sides. First-word-fall-through output via a 2-entry prefetch buffer.
- Generalised successor of the 2-bank dual-port FIFO. Used on datapath buffering where only single-port macros are available.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- FIFO_DEPTH, 32, RAM entries; power of 2, at least 2*NUM_BANKS.
- NUM_BANKS, 4, interleave factor; power of 2, at least 2.
- AFULL_THRESH, FIFO_DEPTH-4: almost_full is asserted when count >= this value.
- AEMPTY_THRESH, 4: almost_empty is asserted when count <= this value.
- CNT_WIDTH, $clog2(FIFO_DEPTH+3), width of count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_valid  in  1  write request.
- wr_data  in  DATA_WIDTH  write payload.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- rd_valid  out  1  rd_data holds the head entry.
- rd_data  out  DATA_WIDTH  head entry; stable while rd_valid && !rd_ready.
- rd_ready  in  1  pop the head when rd_valid && rd_ready.
- count  out  CNT_WIDTH  total occupancy: RAM plus in-flight read plus prefetch buffer.
- almost_full  out  1  registered; count >= AFULL_THRESH.
- almost_empty  out  1  registered; count <= AEMPTY_THRESH.

Behaviour:
- Reset values (rst=1, asynchronous):
  - count=0, rd_valid=0, rd_data=0, almost_full=0, almost_empty=1.
  - All pointers and buffer valid bits cleared.
  - RAM contents are not cleared.
  - Mid-operation reset discards all entries. wr_ready is 0 while rst=1 and 1 in the first cycle after release.
- Pointers: wptr/rptr are $clog2(FIFO_DEPTH)+1 bits, with the wrap bit as MSB.
  - bank = ptr[log2(NUM_BANKS)-1:0]; row = next bits.
  - ram_cnt = wptr - rptr, range 0..FIFO_DEPTH.
- Read issue:
  - A RAM read is issued in a cycle when ram_cnt>0 and (pfb_occupancy + read_in_flight) < 2.
  - The prefetch rule uses registered state only, so there is no combinational path from rd_ready to wr_ready.
  - RAM read latency is 1 cycle; returning data goes to the prefetch buffer.
- Prefetch buffer:
  - 2 entries, FIFO order; rd_data is driven from the head register (registered output).
  - A pop and a refill in the same cycle are both honoured.
- Write accept: wr_ready = !rst && ram_cnt < FIFO_DEPTH && !(read issued this cycle && bank(rptr)==bank(wptr)).
  - On a bank collision the read wins and the write stalls one cycle.
- Latency: write accepted at edge E into an empty FIFO → read issued in cycle E+1 → rd_valid=1 after edge E+2.
- Total capacity: FIFO_DEPTH+2.
  - Full (wr_ready=0 with no collision) iff ram_cnt==FIFO_DEPTH.
  - Empty iff count==0, which implies rd_valid=0.
- Count rules:
  - count += 1 on write handshake, -= 1 on read handshake.
  - Both in the same cycle leave count unchanged.
  - count never exceeds FIFO_DEPTH+2 and never underflows.
- Wrap: pointers wrap modulo 2*FIFO_DEPTH; ordering is preserved across the wrap.
- Banks: internal behavioural single-port arrays, one per bank. Exactly one of read/write per bank per cycle; simulation asserts on violation.

Optional Feature:
- Macro SPRAM_FIFO_PEAK_EN.
- When defined, adds output peak_count (CNT_WIDTH) and input peak_clr (1).
  - peak_count is the maximum count since reset or since the last peak_clr, registered.
  - peak_clr=1 loads the current count.
  - Reset value is 0.
- When undefined, neither port nor its register exists.

Test Plan (DATA_WIDTH=8, FIFO_DEPTH=8, NUM_BANKS=4, AFULL_THRESH=8, AEMPTY_THRESH=2):
- Write single 0xA5 into empty FIFO, rd_ready=0 → rd_valid=1 exactly 2 cycles after the handshake; rd_data=0xA5; count=1; almost_empty=1.
- Write 0x00..0x09 continuously, rd_ready=0 → 10 accepted; wr_ready=0 after the 10th; count=10; almost_full=1; then pop all → 0x00..0x09 in order, count=0.
- Fill to count=5, then wr_valid=rd_ready=1 for 40 cycles with an incrementing pattern → output in order with no loss or duplication across pointer wrap. wr_ready drops only on cycles where bank(rptr)==bank(wptr) with a read issued; each collision delays exactly one write.
- rd_ready toggled 1/0 every cycle with writes of 0x10..0x1F → rd_data held stable while rd_valid && !rd_ready; sequence intact.
- Assert rst at count=6 mid-stream → next cycle count=0, rd_valid=0, almost_empty=1; first post-reset write 0x77 is read back as 0x77.
- SPRAM_FIFO_PEAK_EN: fill to 7, drain to 2 → peak_count=7; pulse peak_clr → peak_count=2.

Source files
------------

// File: rtl/spram_fifo_banked_if.sv
// Write/read valid-ready handshake bundle for spram_fifo_banked.
// master = producer/consumer side, slave = the FIFO.
interface spram_fifo_banked_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;

    modport master (output wr_valid, wr_data, rd_ready,
                    input  wr_ready, rd_valid, rd_data);
    modport slave  (input  wr_valid, wr_data, rd_ready,
                    output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/spram_fifo_banked.sv
// FWFT FIFO over NUM_BANKS interleaved single-port RAM banks with a 2-entry prefetch buffer.
// Optional peak occupancy tracking under `define SPRAM_FIFO_PEAK_EN.
module spram_fifo_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int RW         = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [RW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end
endmodule

module spram_fifo_banked #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 32,
    parameter int NUM_BANKS     = 4,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    parameter int CNT_WIDTH     = $clog2(FIFO_DEPTH + 3)
) (
    input  logic                 clk,
    input  logic                 rst,
    spram_fifo_banked_if.slave   bus,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 almost_full,
    output logic                 almost_empty
`ifdef SPRAM_FIFO_PEAK_EN
    ,
    input  logic                 peak_clr,
    output logic [CNT_WIDTH-1:0] peak_count
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int BW   = $clog2(NUM_BANKS);
    localparam int RW   = AW - BW;
    localparam int ROWS = FIFO_DEPTH / NUM_BANKS;

    logic [PW-1:0] wptr, rptr, ram_cnt;
    logic [BW-1:0] wb, rb, rd_bank_q;
    logic [RW-1:0] wrow, rrow;
    logic          rd_issue, rd_inflight, wr_hs, rd_hs;
    logic [1:0]    pfb_cnt;
    logic [DATA_WIDTH-1:0] pfb0, pfb1, ret_data;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [CNT_WIDTH-1:0] count_nxt;

    assign wb      = wptr[BW-1:0];
    assign rb      = rptr[BW-1:0];
    assign wrow    = wptr[AW-1:BW];
    assign rrow    = rptr[AW-1:BW];
    assign ram_cnt = wptr - rptr;

    // Issue decision looks only at registered state, keeping rd_ready off the wr_ready path.
    assign rd_issue = (ram_cnt != '0) && ((pfb_cnt + {1'b0, rd_inflight}) < 2'd2);

    assign bus.wr_ready = !rst && (ram_cnt < PW'(FIFO_DEPTH)) && !(rd_issue && (rb == wb));
    assign wr_hs        = bus.wr_valid && bus.wr_ready;
    assign rd_hs        = bus.rd_valid && bus.rd_ready;
    assign bus.rd_valid = (pfb_cnt != 2'd0);
    assign bus.rd_data  = pfb0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic we, re;
        assign we = wr_hs    && (wb == BW'(b));
        assign re = rd_issue && (rb == BW'(b));

        spram_fifo_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .RW(RW)) u_bank (
            .clk   (clk),
            .en    (we || re),
            .we    (we),
            .addr  (we ? wrow : rrow),
            .wdata (bus.wr_data),
            .rdata (bank_rdata[b])
        );

        a_single_port: assert property (@(posedge clk) disable iff (rst) !(we && re));
    end

    assign ret_data = bank_rdata[rd_bank_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            rd_inflight <= 1'b0;
            rd_bank_q   <= '0;
        end else begin
            if (wr_hs)    wptr <= wptr + PW'(1);
            if (rd_issue) rptr <= rptr + PW'(1);
            rd_inflight <= rd_issue;
            rd_bank_q   <= rb;
        end
    end

    // Prefetch buffer: pfb0 is the head; a returning word and a pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pfb0    <= '0;
            pfb1    <= '0;
            pfb_cnt <= 2'd0;
        end else begin
            case ({rd_inflight, rd_hs})
                2'b01: begin
                    pfb0    <= pfb1;
                    pfb_cnt <= pfb_cnt - 2'd1;
                end
                2'b10: begin
                    if (pfb_cnt == 2'd0) pfb0 <= ret_data;
                    else                 pfb1 <= ret_data;
                    pfb_cnt <= pfb_cnt + 2'd1;
                end
                2'b11: begin
                    if (pfb_cnt == 2'd1) begin
                        pfb0 <= ret_data;
                    end else begin
                        pfb0 <= pfb1;
                        pfb1 <= ret_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_nxt = count;
        if (wr_hs && !rd_hs)      count_nxt = count + CNT_WIDTH'(1);
        else if (!wr_hs && rd_hs) count_nxt = count - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            almost_full  <= (count_nxt >= CNT_WIDTH'(AFULL_THRESH));
            almost_empty <= (count_nxt <= CNT_WIDTH'(AEMPTY_THRESH));
        end
    end

`ifdef SPRAM_FIFO_PEAK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     peak_count <= '0;
        else if (peak_clr)           peak_count <= count;
        else if (count > peak_count) peak_count <= count;
    end
`endif
endmodule

// File: tb/tb_spram_fifo_banked.sv
// Scoreboard bench for spram_fifo_banked (depth 8, 4 banks); define SPRAM_FIFO_PEAK_EN to cover peak tracking.
module tb_spram_fifo_banked;
    localparam int DW = 8, DEPTH = 8, NB = 4, AF = 8, AE = 2, CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CW-1:0] count;
    logic almost_full, almost_empty;
`ifdef SPRAM_FIFO_PEAK_EN
    logic peak_clr = 1'b0;
    logic [CW-1:0] peak_count;
`endif
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] sb[$];

    spram_fifo_banked_if #(.DATA_WIDTH(DW)) bus ();

    spram_fifo_banked #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_BANKS(NB),
        .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef SPRAM_FIFO_PEAK_EN
        ,
        .peak_clr     (peak_clr),
        .peak_count   (peak_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: head compared whenever output is valid, pushed on write handshake.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_head got=%h expected=<empty>", bus.rd_data);
            end else if (bus.rd_data !== sb[0]) begin
                failures++;
                $display("FAIL sb_head got=%h expected=%h", bus.rd_data, sb[0]);
            end
            if (bus.rd_ready && sb.size() != 0) void'(sb.pop_front());
        end
        if (bus.wr_valid && bus.wr_ready) sb.push_back(bus.wr_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_items(input logic [DW-1:0] start, input int n);
        int acc = 0;
        int guard = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = start;
        while (acc < n && guard < 200) begin
            @(negedge clk);
            if (bus.wr_ready) acc++;
            step();
            guard++;
            bus.wr_data = DW'(start + DW'(acc));
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (acc != n) begin
            failures++;
            $display("FAIL push_timeout accepted=%0d required=%0d", acc, n);
        end
    endtask

    task automatic pop_items(input int n);
        int got = 0;
        int guard = 0;
        bus.rd_ready = 1'b1;
        while (got < n && guard < 200) begin
            @(negedge clk);
            if (bus.rd_valid) got++;
            step();
            guard++;
        end
        bus.rd_ready = 1'b0;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL pop_timeout popped=%0d required=%0d", got, n);
        end
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        bus.rd_ready = 1'b1;
        while (guard < 200) begin
            @(negedge clk);
            if (count == 0) break;
            step();
            guard++;
        end
        bus.rd_ready = 1'b0;
        checks++;
        if (count !== 0 || bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain count=%0d rd_valid=%b required 0/0", tag, count, bus.rd_valid);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_lost_entries left=%0d required=0", tag, sb.size());
        end
        checks++;
        if (almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL %s_aempty got=%b required=1", tag, almost_empty);
        end
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (count !== 0 || bus.rd_valid !== 0 || bus.rd_data !== 0 ||
            almost_full !== 0 || almost_empty !== 1 || bus.wr_ready !== 0) begin
            failures++;
            $display("FAIL reset_values cnt=%0d rv=%b rd=%h af=%b ae=%b wr=%b required 0/0/00/0/1/0",
                     count, bus.rd_valid, bus.rd_data, almost_full, almost_empty, bus.wr_ready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_wr_ready got=%b required=1", bus.wr_ready);
        end
        step();
    endtask

    task automatic test_single();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_wr_ready got=%b required=1", bus.wr_ready);
        end
        step();
        bus.wr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.rd_valid !== (k == 3)) begin
                failures++;
                $display("FAIL single_latency cycle=%0d rd_valid=%b required=%b", k, bus.rd_valid, k == 3);
            end
            checks++;
            if (count !== 1) begin
                failures++;
                $display("FAIL single_count cycle=%0d got=%0d required=1", k, count);
            end
            if (k < 3) step();
        end
        checks++;
        if (bus.rd_data !== 8'hA5 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL single_data rd=%h ae=%b required a5/1", bus.rd_data, almost_empty);
        end
        step();
        drain("single");
    endtask

    task automatic test_fill();
        push_items(8'h00, 10);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_ready !== 1'b0) begin
                failures++;
                $display("FAIL fill_full_wr_ready got=%b required=0", bus.wr_ready);
            end
            step();
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 4'd10 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            failures++;
            $display("FAIL fill_flags cnt=%0d af=%b ae=%b required 10/1/0", count, almost_full, almost_empty);
        end
        step();
        drain("fill");
    endtask

    task automatic test_stream();
        logic [DW-1:0] v = 8'h55;
        bit prev_stall = 0;
        bit stall;
        push_items(8'h50, 5);
        bus.wr_valid = 1'b1;
        bus.rd_ready = 1'b1;
        bus.wr_data  = v;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stall = !bus.wr_ready && (count < 4'(DEPTH));
            checks++;
            if (stall && prev_stall) begin
                failures++;
                $display("FAIL stream_double_stall cycle=%0d count=%0d", c, count);
            end
            checks++;
            if (count > 4'(DEPTH + 2)) begin
                failures++;
                $display("FAIL stream_count_bound got=%0d required<=%0d", count, DEPTH + 2);
            end
            if (bus.wr_ready) v++;
            prev_stall = stall;
            step();
            bus.wr_data = v;
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (v < 8'h55 + 8'd20) begin
            failures++;
            $display("FAIL stream_throughput last=%h required>=%h", v, 8'h55 + 8'd20);
        end
        drain("stream");
    endtask

    task automatic test_toggle();
        logic [DW-1:0] held = '0;
        bit hold = 0;
        int acc = 0;
        int guard = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h10;
        bus.rd_ready = 1'b0;
        while ((acc < 16 || count != 0) && guard < 300) begin
            @(negedge clk);
            if (hold) begin
                checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== held) begin
                    failures++;
                    $display("FAIL toggle_hold rv=%b rd=%h required 1/%h", bus.rd_valid, bus.rd_data, held);
                end
            end
            hold = bus.rd_valid && !bus.rd_ready;
            held = bus.rd_data;
            if (bus.wr_valid && bus.wr_ready) acc++;
            step();
            guard++;
            bus.rd_ready = ~bus.rd_ready;
            bus.wr_valid = (acc < 16);
            bus.wr_data  = DW'(8'h10 + DW'(acc));
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        checks++;
        if (acc != 16 || guard >= 300) begin
            failures++;
            $display("FAIL toggle_timeout accepted=%0d required=16", acc);
        end
        drain("toggle");
    endtask

    task automatic test_midreset();
        push_items(8'h40, 6);
        @(negedge clk);
        checks++;
        if (count !== 4'd6) begin
            failures++;
            $display("FAIL midrst_precount got=%0d required=6", count);
        end
        step();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        bus.rd_ready = 1'b1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (count !== 0 || bus.rd_valid !== 0 || almost_empty !== 1 || bus.wr_ready !== 0) begin
            failures++;
            $display("FAIL midrst_state cnt=%0d rv=%b ae=%b wr=%b required 0/0/1/0",
                     count, bus.rd_valid, almost_empty, bus.wr_ready);
        end
        step();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b1 || count !== 0) begin
            failures++;
            $display("FAIL midrst_release wr=%b cnt=%0d required 1/0", bus.wr_ready, count);
        end
        step();
        push_items(8'h77, 1);
        pop_items(1);
        drain("midrst");
    endtask

`ifdef SPRAM_FIFO_PEAK_EN
    task automatic test_peak();
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        push_items(8'h20, 7);
        pop_items(5);
        @(negedge clk);
        checks++;
        if (count !== 4'd2 || peak_count !== 4'd7) begin
            failures++;
            $display("FAIL peak_max cnt=%0d peak=%0d required 2/7", count, peak_count);
        end
        step();
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (peak_count !== 4'd2) begin
            failures++;
            $display("FAIL peak_clr got=%0d required=2", peak_count);
        end
        step();
        drain("peak");
    endtask
`endif

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_toggle();
        test_midreset();
`ifdef SPRAM_FIFO_PEAK_EN
        test_peak();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
